// File: rtl/multicycle_control.sv
// Multicycle control FSM for a small ARM-style datapath (FETCH/DECODE/EXEC/MEM/WB).
// Outputs are combinational from state/opcode/zero/mem_ready; memory waits stall in place.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ALUOp1,
  output logic             ALUOp0,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_ADDR   = 4'd3;
  localparam logic [3:0] S_MEM_RD = 4'd4;
  localparam logic [3:0] S_MEM_WR = 4'd5;
  localparam logic [3:0] S_WB_R   = 4'd6;
  localparam logic [3:0] S_WB_LD  = 4'd7;
  localparam logic [3:0] S_CBZ    = 4'd8;
  localparam logic [3:0] S_BR     = 4'd9;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire_d;
  logic             is_r, is_ld, is_st, is_cbz, is_b;

  // The instruction register holds opcode steady for the whole instruction.
  assign is_r   = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                  (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
  assign is_ld  = (opcode == 11'b11111000010);
  assign is_st  = (opcode == 11'b11111000000);
  assign is_cbz = (opcode[10:3] == 8'b10110100);
  assign is_b   = (opcode[10:5] == 6'b000101);

  always_comb begin
    state_d    = state_q;
    retire_d   = 1'b0;
    ALUOp1     = 1'b0;
    ALUOp0     = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    Reg2Loc    = 1'b0;
    ALUSrc     = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_r)                state_d = S_EXEC_R;
        else if (is_ld || is_st) state_d = S_ADDR;
        else if (is_cbz)         state_d = S_CBZ;
        else if (is_b)           state_d = S_BR;
        else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUOp1  = 1'b1;
        state_d = S_WB_R;
      end
      S_ADDR: begin
        ALUSrc  = 1'b1;
        Reg2Loc = is_st;
        state_d = is_st ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) state_d = S_WB_LD;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        Reg2Loc  = 1'b1;
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_WB_LD: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_CBZ: begin
        ALUOp0   = 1'b1;
        Reg2Loc  = 1'b1;
        PCWrite  = zero;
        PCSrc    = zero;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_BR: begin
        PCWrite  = 1'b1;
        PCSrc    = 1'b1;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset overrides every control regardless of state or inputs.
    if (reset) begin
      ALUOp1     = 1'b0;
      ALUOp0     = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      Reg2Loc    = 1'b0;
      ALUSrc     = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      illegal_op = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_d) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction step lists drive an expected
// state/output trace and a modulo-16 retired count.
module tb_multicycle_control;

  localparam int CW = 4;
  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [10:0] opcode = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic ALUOp1, ALUOp0, IorD, IRWrite, MemRead, MemWrite, MemtoReg;
  logic RegWrite, Reg2Loc, ALUSrc, PCWrite, PCSrc, illegal_op;
  logic [3:0] state;
  logic [CW-1:0] retired;

  int n_checks = 0;
  int n_err = 0;
  int steps[$];
  logic [10:0] pending[$];
  int cur_cls = C_ILL;
  int rcount = 0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .IorD(IorD), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .illegal_op(illegal_op), .state(state), .retired(retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int classify(input logic [10:0] op);
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return C_R;
    if (op == 11'b11111000010) return C_LD;
    if (op == 11'b11111000000) return C_ST;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op[10:5] == 6'b000101) return C_B;
    return C_ILL;
  endfunction

  function automatic logic [10:0] rand_op();
    logic [10:0] op;
    logic [10:0] r_ops [4];
    r_ops[0] = 11'b10001011000; r_ops[1] = 11'b11001011000;
    r_ops[2] = 11'b10001010000; r_ops[3] = 11'b10101010000;
    case ($urandom_range(0, 5))
      0: op = r_ops[$urandom_range(0, 3)];
      1: op = 11'b11111000010;
      2: op = 11'b11111000000;
      3: op = {8'b10110100, 3'($urandom)};
      4: op = {6'b000101, 5'($urandom)};
      default: begin
        op = 11'($urandom);
        for (int k = 0; k < 50 && classify(op) != C_ILL; k++) op = 11'($urandom);
        if (classify(op) != C_ILL) op = 11'b00000000000;
      end
    endcase
    return op;
  endfunction

  // Expected controls {ALUOp1,ALUOp0,IorD,IRWrite,MemRead,MemWrite,MemtoReg,RegWrite,Reg2Loc,ALUSrc,PCWrite,PCSrc,illegal_op}
  function automatic logic [12:0] exp_ctrl(input int st, input int cls, input logic z, input logic mr);
    logic [1:0] aluop;
    logic iord, irw, mrd, mwr, m2r, rw, r2l, asrc, pcw, pcs, ill;
    {aluop, iord, irw, mrd, mwr, m2r, rw, r2l, asrc, pcw, pcs, ill} = '0;
    case (st)
      0: begin mrd = 1'b1; irw = mr; pcw = mr; end
      1: ill = (cls == C_ILL);
      2: aluop = 2'b10;
      3: begin asrc = 1'b1; r2l = (cls == C_ST); end
      4: begin iord = 1'b1; mrd = 1'b1; end
      5: begin iord = 1'b1; mwr = 1'b1; r2l = 1'b1; end
      6: rw = 1'b1;
      7: begin rw = 1'b1; m2r = 1'b1; end
      8: begin aluop = 2'b01; r2l = 1'b1; pcw = z; pcs = z; end
      9: begin pcw = 1'b1; pcs = 1'b1; end
      default: ;
    endcase
    return {aluop, iord, irw, mrd, mwr, m2r, rw, r2l, asrc, pcw, pcs, ill};
  endfunction

  task automatic load_next();
    logic [10:0] op;
    if (pending.size() > 0) op = pending.pop_front();
    else op = rand_op();
    opcode = op;
    cur_cls = classify(op);
    case (cur_cls)
      C_R:   steps = '{0, 1, 2, 6};
      C_LD:  steps = '{0, 1, 3, 4, 7};
      C_ST:  steps = '{0, 1, 3, 5};
      C_CBZ: steps = '{0, 1, 8};
      C_B:   steps = '{0, 1, 9};
      default: steps = '{0, 1};
    endcase
  endtask

  task automatic cycle(input logic rst, input logic mr, input logic z);
    int st_exp;
    logic [12:0] obs;
    @(posedge clk);
    #1;
    if (!rst && steps.size() == 0) load_next();
    reset = rst;
    mem_ready = mr;
    zero = z;
    #1;
    st_exp = (steps.size() > 0) ? steps[0] : 0;
    obs = {ALUOp1, ALUOp0, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
           RegWrite, Reg2Loc, ALUSrc, PCWrite, PCSrc, illegal_op};
    check_eq("state", 32'(state), 32'(st_exp));
    check_eq("retired", 32'(retired), 32'(rcount));
    check_eq("ctrl", 32'(obs), rst ? 32'd0 : 32'(exp_ctrl(st_exp, cur_cls, z, mr)));
    if (rst) begin
      steps.delete();
      rcount = 0;
    end else if (!((st_exp == 0 || st_exp == 4 || st_exp == 5) && !mr)) begin
      void'(steps.pop_front());
      if (steps.size() == 0 && cur_cls != C_ILL) rcount = (rcount + 1) % 16;
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 11'b11111000000;
    @(posedge clk);
    @(posedge clk);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);

    pending.push_back(11'b10001011000);
    repeat (4) cycle(1'b0, 1'b1, 1'b0);

    pending.push_back(11'b11111000010);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, 1'b0);

    pending.push_back(11'b10110100101);
    pending.push_back(11'b10110100101);
    repeat (3) cycle(1'b0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);

    pending.push_back(11'b00000000000);
    repeat (2) cycle(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) pending.push_back({6'b000101, 5'(i)});
    repeat (48) cycle(1'b0, 1'b1, 1'b1);

    pending.push_back(11'b11111000000);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 7), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 11, instruction bits [31:21] from the instruction register.
REQ-005 SHALL have port zero, input, 1, ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-007 SHALL have ports ALUOp1 and ALUOp0, output, 1 each, to the ALU control decoder.
REQ-008 SHALL have ports IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, Reg2Loc, ALUSrc, PCWrite, PCSrc, output, 1 each, datapath controls.
REQ-009 SHALL have port illegal_op, output, 1, one-cycle pulse on an unrecognised opcode.
REQ-010 SHALL have port state, output, 4, current FSM state code.
REQ-011 SHALL have port retired, output, CNT_W, count of completed instructions.

Function
REQ-012 SHALL use states FETCH=0, DECODE=1, EXEC_R=2, ADDR=3, MEM_RD=4, MEM_WR=5, WB_R=6, WB_LD=7, CBZ=8, BR=9. Codes 10-15 are unused.
REQ-013 SHALL decode classes in DECODE:
- R: 10001011000, 11001011000, 10001010000, 10101010000.
- LDUR: 11111000010.
- STUR: 11111000000.
- CBZ: opcode[10:3]=10110100.
- B: opcode[10:5]=000101.
- Any other opcode is illegal.
REQ-014 SHALL use these transitions:
- FETCH -> DECODE when mem_ready=1; otherwise stay in FETCH.
- DECODE -> EXEC_R for R, ADDR for LDUR/STUR, CBZ for CBZ, BR for B.
- DECODE -> FETCH for an illegal opcode, with illegal_op=1 in that DECODE cycle.
- EXEC_R -> WB_R -> FETCH.
- ADDR -> MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD -> WB_LD when mem_ready=1; otherwise stay in MEM_RD.
- MEM_WR -> FETCH when mem_ready=1; otherwise stay in MEM_WR.
- WB_LD -> FETCH.
- CBZ -> FETCH.
- BR -> FETCH.
REQ-015 SHALL generate all control outputs combinationally from state, opcode class, zero and mem_ready (Moore except where gated). Any output not listed for a state SHALL be 0.
REQ-016 FETCH SHALL drive IorD=0 and MemRead=1, plus IRWrite=1 and PCWrite=1 (PC+4, PCSrc=0) only while mem_ready=1.
REQ-017 EXEC_R SHALL drive {ALUOp1,ALUOp0}=10 and ALUSrc=0, with Reg2Loc=0.
REQ-018 ADDR SHALL drive ALUOp=00 and ALUSrc=1; for STUR it SHALL also drive Reg2Loc=1.
REQ-019 MEM_RD SHALL drive IorD=1 and MemRead=1.
REQ-020 MEM_WR SHALL drive IorD=1 and MemWrite=1, with Reg2Loc=1.
REQ-021 WB_R SHALL drive RegWrite=1 and MemtoReg=0.
REQ-022 WB_LD SHALL drive RegWrite=1 and MemtoReg=1.
REQ-023 CBZ SHALL drive ALUOp=01, Reg2Loc=1 and ALUSrc=0; it SHALL drive PCWrite=PCSrc=zero.
REQ-024 BR SHALL drive PCWrite=1 and PCSrc=1, with ALUOp=00.
REQ-025 SHALL increment retired by 1 on the final cycle of each legal instruction, wrapping from 2^CNT_W-1 to 0. The final cycle is:
- WB_R.
- WB_LD.
- MEM_WR with mem_ready=1.
- CBZ.
- BR.
REQ-026 An illegal opcode SHALL NOT increment retired.
REQ-027 MemRead and MemWrite SHALL never be 1 in the same cycle.
REQ-028 RegWrite SHALL never be 1 in FETCH, DECODE, ADDR, MEM_RD or MEM_WR.
REQ-029 SHALL hold state and all outputs stable while waiting on mem_ready=0, for an unbounded number of cycles.
REQ-030 If state ever holds an unused code (10-15), the FSM SHALL go to FETCH on the next edge with all outputs 0.

Reset
REQ-031 While reset=1, on every rising edge, state SHALL be set to FETCH and retired SHALL be set to 0.
REQ-032 While reset=1, all control outputs and illegal_op SHALL be forced to 0, regardless of other inputs.
REQ-033 Reset asserted in any state, including mid-memory-wait, SHALL abort the instruction without incrementing retired.
REQ-034 The first fetch SHALL begin on the first edge after reset deasserts.

Verification
REQ-035 Reset, then mem_ready=1 constantly, opcode=10001011000 (ADD) -> states 0,1,2,6,0; ALUOp=10 in EXEC_R; RegWrite=1 only in WB_R; retired=1.
REQ-036 LDUR 11111000010 with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with MemRead=1 and IorD=1; then WB_LD with MemtoReg=1 and RegWrite=1; retired increments once.
REQ-037 CBZ 10110100101 run twice, once with zero=1 and once with zero=0 -> ALUOp=01 both times; PCWrite=PCSrc=1 only when zero=1; retired=2.
REQ-038 Opcode 00000000000 -> illegal_op=1 for exactly one cycle in DECODE; next state FETCH; retired unchanged.
REQ-039 CNT_W=4, 16 consecutive B instructions (000101xxxxx) -> retired wraps 15 -> 0; PCWrite=PCSrc=1 in each BR cycle.
REQ-040 Reset asserted during MEM_WR while mem_ready=0 -> next edge state=0 and retired=0; MemWrite=0 while reset=1.
